// File: rtl/arbiter_control.sv
// Arbiter control FSM sharing one physical-memory port between the I-cache and D-cache.
// Grants one side at a time, steers the datapath mux and forwards the completion to that side only.
module arbiter_control #(
  parameter bit DATA_PRIORITY = 1'b1,
  parameter int MAX_CONSEC    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inst_read,
  input  logic data_read,
  input  logic data_write,
  input  logic pmem_resp,
  output logic mux_sel,
  output logic pmem_read,
  output logic pmem_write,
  output logic inst_resp,
  output logic data_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

  state_t     state_reg, state_next;
  logic [3:0] consec_reg, consec_next;
  logic       last_grant_reg, last_grant_next;  // 0 = instruction side, 1 = data side

  logic data_pending;
  logic grant_data;
  logic other_pending;
  logic starve_guard;

  assign data_pending = data_read | data_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      consec_reg     <= 4'd0;
      last_grant_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      consec_reg     <= consec_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    consec_next     = consec_reg;
    last_grant_next = last_grant_reg;
    mux_sel         = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    inst_resp       = 1'b0;
    data_resp       = 1'b0;
    grant_data      = 1'b0;
    other_pending   = 1'b0;
    starve_guard    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (inst_read || data_pending) begin
          // The priority side loses a tie once it has run MAX_CONSEC grants in a row.
          if (inst_read && data_pending) begin
            starve_guard = (consec_reg == MAX_C) && (last_grant_reg == DATA_PRIORITY);
            grant_data   = starve_guard ? ~DATA_PRIORITY : DATA_PRIORITY;
          end else begin
            grant_data = data_pending;
          end
          other_pending = grant_data ? inst_read : data_pending;

          if ((grant_data == last_grant_reg) && other_pending) begin
            consec_next = (consec_reg >= MAX_C) ? MAX_C : consec_reg + 4'd1;
          end else begin
            consec_next = 4'd1;
          end
          last_grant_next = grant_data;
          state_next      = grant_data ? SERVE_D : SERVE_I;
        end
      end

      SERVE_I: begin
        pmem_read = 1'b1;
        inst_resp = pmem_resp;
        if (pmem_resp) state_next = IDLE;
      end

      SERVE_D: begin
        mux_sel    = 1'b1;
        pmem_read  = data_read;
        pmem_write = data_write;
        data_resp  = pmem_resp;
        if (pmem_resp) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/arbiter_control.md
Name: arbiter_control

Overview:
- Control FSM that shares the single physical-memory port between the instruction cache and the data cache.
- Accepts read requests from the I-cache and read/write requests from the D-cache.
- Grants one requester at a time, drives the `mux_sel` that steers address/wdata/rdata in the arbiter datapath, and forwards `pmem_read`/`pmem_write`.
- Returns `pmem_resp` to the granted cache only. Sits between the two caches and the cacheline adaptor / physical memory.

Parameters:
- DATA_PRIORITY, 1, 1 = D-cache wins simultaneous requests; 0 = I-cache wins.
- MAX_CONSEC, 4, max back-to-back grants to the priority side while the other side is waiting (anti-starvation); range 1..15.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- inst_read  in  1  I-cache line read request, held until inst_resp
- data_read  in  1  D-cache line read request, held until data_resp
- data_write  in  1  D-cache line write-back request, held until data_resp; never asserted with data_read
- pmem_resp  in  1  physical memory completion for current transaction (1 cycle)
- mux_sel  out  1  datapath steer: 0 = instruction side, 1 = data side
- pmem_read  out  1  read request to physical memory
- pmem_write  out  1  write request to physical memory
- inst_resp  out  1  completion to I-cache
- data_resp  out  1  completion to D-cache

Behaviour:
- Reset (rst=1 at clock edge, including mid-transaction): state=IDLE, consec counter=0, last_grant=0.
  - All outputs 0 on the cycle after reset is sampled.
  - An in-flight pmem transaction is abandoned; no resp is forwarded.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE: all outputs 0, mux_sel=0.
  - Only inst pending -> SERVE_I.
  - Only data (read or write) pending -> SERVE_D.
  - Both pending -> priority side per DATA_PRIORITY, unless consec == MAX_CONSEC and last_grant was the priority side; then the non-priority side.
  - Neither pending -> stay.
- SERVE_I: mux_sel=0, pmem_read=1, pmem_write=0.
  - inst_resp = pmem_resp (combinational, same cycle).
  - On pmem_resp -> IDLE.
- SERVE_D: mux_sel=1.
  - pmem_read = data_read, pmem_write = data_write (request type sampled live, stable by contract).
  - data_resp = pmem_resp.
  - On pmem_resp -> IDLE.
- Grant latency: request seen in IDLE at edge N -> pmem_read/pmem_write asserted from cycle N+1. Minimum gap between successive transactions is one IDLE cycle.
- Consec counter (4 bits):
  - Updated on each IDLE->SERVE transition.
  - Same side as last_grant and the other side pending -> increment, saturating at MAX_CONSEC.
  - Different side -> reset to 1.
  - Other side not pending -> hold at 1.
  - last_grant updates to the granted side.
- inst_resp and data_resp are never both 1. They are never 1 outside the matching SERVE state.
- pmem_resp arriving in IDLE is ignored.
- Requester drops its request before resp (protocol violation): FSM remains in SERVE until pmem_resp. In SERVE_D, pmem_read/pmem_write fall to 0 with the request.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no requests -> all outputs 0 and mux_sel=0 for 10 cycles.
- Single I-fetch: inst_read=1 at cycle 0, pmem_resp at cycle 5 ->
  - pmem_read=1, mux_sel=0 from cycle 1.
  - inst_resp=1 only at cycle 5.
  - IDLE at cycle 6.
- D-cache write-back: data_write=1, pmem_resp after 4 cycles -> pmem_write=1, pmem_read=0, mux_sel=1, data_resp pulse coincident with pmem_resp.
- Simultaneous, DATA_PRIORITY=1: inst_read=data_read=1 at cycle 0 ->
  - SERVE_D first, data_resp.
  - One IDLE cycle, then SERVE_I with inst_resp.
- Starvation guard, MAX_CONSEC=4: inst_read held high, data_read re-asserted immediately after every data_resp -> exactly 4 data grants, then 1 inst grant, then data resumes.
- Reset mid-transaction: rst pulsed during SERVE_D before pmem_resp -> next cycle IDLE, pmem_read=0, data_resp never pulses; a following pmem_resp is ignored.
